// File: rtl/online_mult_seq.sv
// online_mult_seq: iteration sequencer for the radix-2 on-line multiplier residual datapath.
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   start / busy / done     start request (IDLE only), activity flag, one-cycle completion pulse
//   x_digit, y_digit        operand digits {pos,neg}, accepted via in_valid / in_ready
//   sample_for_P            3-bit signed residual sample feeding the digit selection
//   dp_init, dp_step        datapath clear and iteration strobes
//   dp_zero_in              datapath uses zero operand digits (tail iterations)
//   dp_sel_digit            selected digit fed back to the residual update
//   iter                    iterations completed since start
//   p_digit / p_valid       product digit stream, accepted via p_ready
//   err                     sticky illegal-digit flag
// Optional: define ONLINE_DIGIT_CHECK_EN to flag consumed operand digits equal to 11.
module online_mult_seq #(
   parameter int Num_bits      = 4,
   parameter int on_line_delay = 3,
   parameter int CNT_W         = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic [1:0]       x_digit,
   input  logic [1:0]       y_digit,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       sample_for_P,
   output logic             dp_init,
   output logic             dp_step,
   output logic             dp_zero_in,
   output logic [1:0]       dp_sel_digit,
   output logic [CNT_W-1:0] iter,
   output logic [1:0]       p_digit,
   output logic             p_valid,
   input  logic             p_ready,
   output logic             err
);
   typedef enum logic [2:0] {IDLE, INIT, RUN, TAIL, DRAIN} state_t;
   localparam logic [CNT_W-1:0] INIT_END = CNT_W'(on_line_delay);
   localparam logic [CNT_W-1:0] RUN_END  = CNT_W'(Num_bits);
   localparam logic [CNT_W-1:0] TAIL_END = CNT_W'(Num_bits + on_line_delay);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] iter_q, iter_d, iter_inc;
   logic [1:0]       p_digit_q, p_digit_d, sel;
   logic             p_valid_q, p_valid_d, ofree, emit;
   assign ofree    = !p_valid_q || p_ready;
   assign iter_inc = iter_q + 1'b1;
   // s >= 1 -> +1; s in {0,-1} -> 0; s <= -2 -> -1
   assign sel = (!sample_for_P[2] && |sample_for_P[1:0]) ? 2'b10 :
                (sample_for_P[2] && !(&sample_for_P[1:0])) ? 2'b01 : 2'b00;
   always_comb begin
      state_d    = state_q;
      iter_d     = iter_q;
      in_ready   = 1'b0;
      dp_init    = 1'b0;
      dp_step    = 1'b0;
      dp_zero_in = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            dp_init = 1'b1;
            iter_d  = '0;
            state_d = INIT;
         end
         INIT: begin
            in_ready = 1'b1;
            dp_step  = in_valid;
            if (in_valid && iter_inc == INIT_END) state_d = RUN;
         end
         RUN: begin
            in_ready = ofree;
            dp_step  = in_valid && ofree;
            if (dp_step && iter_inc == RUN_END) state_d = TAIL;
         end
         TAIL: begin
            dp_zero_in = 1'b1;
            dp_step    = ofree;
            if (ofree && iter_inc == TAIL_END) state_d = DRAIN;
         end
         DRAIN: if (ofree) begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (dp_step) iter_d = iter_inc;
      // Only output-producing iterations load the product register
      emit         = dp_step && (state_q == RUN || state_q == TAIL);
      dp_sel_digit = emit ? sel : 2'b00;
      p_digit_d    = emit ? sel : p_digit_q;
      p_valid_d    = emit || (p_valid_q && !p_ready);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         iter_q    <= '0;
         p_digit_q <= 2'b00;
         p_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         iter_q    <= iter_d;
         p_digit_q <= p_digit_d;
         p_valid_q <= p_valid_d;
      end
   end
   assign busy    = state_q != IDLE;
   assign iter    = iter_q;
   assign p_digit = p_digit_q;
   assign p_valid = p_valid_q;
`ifdef ONLINE_DIGIT_CHECK_EN
   logic err_q, err_d;
   // Only digits actually consumed are checked; a fresh start clears the flag
   assign err_d = dp_init ? 1'b0 :
                  (dp_step && in_ready && (&x_digit || &y_digit)) ? 1'b1 : err_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= err_d;
   end
   assign err = err_q;
`else
   logic unused_digits;
   assign unused_digits = ^{x_digit, y_digit};
   assign err = 1'b0;
`endif
endmodule
